// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: RV32I load/store size
// codes, clear-controller state encoding and the alignment helper.
package dmem_pkg;

    // RV32I funct3 codes for loads/stores; anything else is handled as a word.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_t;

    // True when the byte offset is not naturally aligned for the access size.
    function automatic logic size_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        case (funct3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return addr_lo[0];
            default:     return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_clear_ctrl.sv
// Post-reset clear sequencer: walks every word index once, asserting a
// write strobe for each, then parks in READY until the next reset.
module dmem_clear_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    dmem_state_t       state;
    logic [ADDR_W-1:0] cnt;

    // Sweep state and counter; a low reset on any edge restarts the sweep.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state <= READY;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    // The reset edge itself must not write, so the strobe is gated by reset.
    assign clr_we  = (state == CLEAR) && reset;
    assign clr_idx = cnt;
    assign busy    = (state == CLEAR);

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed, word-organised data memory with RV32I load/store sizing,
// byte-lane write enables and a hardware clear sweep after reset.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to flag and suppress
// misaligned accesses instead of forcing them to natural alignment.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_address,
    input  logic [31:0] in_write_data,
    input  logic        in_write_enable,
    input  logic        in_read_enable,
    input  logic [2:0]  in_funct3,
    output logic [31:0] out_data,
    output logic        out_busy,
    output logic        out_misaligned
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [31:0]       mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              ready;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane_off;
    logic [3:0]        byte_en;
    logic [31:0]       wr_lanes;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       rd_ext;
    logic              trap;
    logic              store_en;
    logic              unused_addr;

    dmem_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk     (clk),
        .reset   (reset),
        .clr_we  (clr_we),
        .clr_idx (clr_idx),
        .busy    (out_busy)
    );

    assign ready       = !out_busy;
    assign idx         = in_address[ADDR_W+1:2];
    assign unused_addr = ^in_address[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap           = size_misaligned(in_funct3, in_address[1:0]);
    assign out_misaligned = ready && (in_write_enable || in_read_enable) && trap;
`else
    assign trap           = 1'b0;
    assign out_misaligned = 1'b0;
`endif

    // Lane offset forced to natural alignment, plus store lane enables/data.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        lane_off = 2'b00;
        byte_en  = 4'b1111;
        wr_lanes = in_write_data;
        case (in_funct3)
            F3_B, F3_BU: begin
                lane_off = in_address[1:0];
                byte_en  = 4'b0001 << lane_off;
                wr_lanes = {4{in_write_data[7:0]}};
            end
            F3_H, F3_HU: begin
                lane_off = {in_address[1], 1'b0};
                byte_en  = 4'b0011 << lane_off;
                wr_lanes = {2{in_write_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign store_en = ready && reset && in_write_enable && !trap;

    // Array write port: clear sweep has priority, otherwise lane-masked stores.
    // NOTE: the array has no reset branch; the clear FSM zeroes it instead,
    // which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    // Combinational load path: lane extraction and sign/zero extension.
    always_comb begin
        rd_word  = mem[idx];
        rd_shift = rd_word >> {lane_off, 3'b000};
        case (in_funct3)
            F3_B:    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_H:    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_BU:   rd_ext = {24'h0, rd_shift[7:0]};
            F3_HU:   rd_ext = {16'h0, rd_shift[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    assign out_data = (ready && in_read_enable && !trap) ? rd_ext : 32'h0;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: directed loads/stores with a
// scoreboard queue, plus clear-sweep timing and reset-restart checks.
module tb_dmem_bytelane;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_address;
    logic [31:0] in_write_data;
    logic        in_write_enable;
    logic        in_read_enable;
    logic [2:0]  in_funct3;
    logic [31:0] out_data;
    logic        out_busy;
    logic        out_misaligned;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    dmem_bytelane #(.DEPTH(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_address      (in_address),
        .in_write_data   (in_write_data),
        .in_write_enable (in_write_enable),
        .in_read_enable  (in_read_enable),
        .in_funct3       (in_funct3),
        .out_data        (out_data),
        .out_busy        (out_busy),
        .out_misaligned  (out_misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        in_write_enable = we;
        in_read_enable  = re;
        in_funct3       = f3;
        in_address      = addr;
        in_write_data   = wd;
    endtask

    // One access for one cycle; the expected outputs go to the scoreboard.
    task automatic op(input string tag, input logic we, input logic re,
                      input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_d,
                      input logic exp_m);
        @(negedge clk);
        drive(we, re, f3, addr, wd);
        q.push_back('{tag, exp_d, exp_m});
    endtask

    task automatic idle();
        @(negedge clk);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    endtask

    // Pulse reset for two edges, release, and measure how long busy stays up.
    // A read of 0xFC and a store to 0x00 are issued mid-sweep.
    task automatic reset_and_sweep(input string tag, input int abort_after);
        int n;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (out_busy === 1'b1 && n < 200 && (abort_after == 0 || n < abort_after)) begin
            n++;
            if (n == 1) begin
                drive(1'b0, 1'b1, F3_W, 32'hFC, 32'h0);
                #2;
                check({tag, "_clear_rd"}, out_data, 32'h0);
            end else if (n == 60) begin
                drive(1'b1, 1'b1, F3_W, 32'h00, 32'h0BADF00D);
                #2;
                check({tag, "_clear_mis"}, {31'h0, out_misaligned}, 32'h0);
            end else begin
                drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
            end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        check({tag, "_busy_cycles"}, 32'(n), (abort_after == 0) ? 32'd64 : 32'(abort_after));
    endtask

    // Scoreboard consumer: compares the combinational outputs mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.tag, "_data"}, out_data, e.data);
                check({e.tag, "_mis"}, {31'h0, out_misaligned}, {31'h0, e.mis});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'h0, out_busy}, 32'h1);
        check("rst_data", out_data, 32'h0);
        check("rst_mis", {31'h0, out_misaligned}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        begin : first_sweep
            int n;
            n = 0;
            while (out_busy === 1'b1 && n < 200) begin
                n++;
                @(negedge clk);
            end
            check("sweep_cycles", 32'(n), 32'd64);
        end

        for (int a = 0; a < 256; a += 60) begin
            op("lw_zero", 1'b0, 1'b1, F3_W, 32'(a & 32'hFC), 32'h0, 32'h0, 1'b0);
        end

        op("sw_10",  1'b1, 1'b0, F3_W,  32'h10, 32'h80FF7F01, 32'h0, 1'b0);
        op("lb_10",  1'b0, 1'b1, F3_B,  32'h10, 32'h0, 32'h00000001, 1'b0);
        op("lb_11",  1'b0, 1'b1, F3_B,  32'h11, 32'h0, 32'h0000007F, 1'b0);
        op("lb_12",  1'b0, 1'b1, F3_B,  32'h12, 32'h0, 32'hFFFFFFFF, 1'b0);
        op("lbu_12", 1'b0, 1'b1, F3_BU, 32'h12, 32'h0, 32'h000000FF, 1'b0);
        op("lh_12",  1'b0, 1'b1, F3_H,  32'h12, 32'h0, 32'hFFFF80FF, 1'b0);
        op("lhu_12", 1'b0, 1'b1, F3_HU, 32'h12, 32'h0, 32'h000080FF, 1'b0);
        op("lw_10",  1'b0, 1'b1, F3_W,  32'h10, 32'h0, 32'h80FF7F01, 1'b0);
        op("lb_13",  1'b0, 1'b1, F3_B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0);

        op("sw_20",  1'b1, 1'b0, F3_W,  32'h20, 32'h11223344, 32'h0, 1'b0);
        op("sb_23",  1'b1, 1'b0, F3_B,  32'h23, 32'h123456AA, 32'h0, 1'b0);
        op("lw_20a", 1'b0, 1'b1, F3_W,  32'h20, 32'h0, 32'hAA223344, 1'b0);
        op("sh_20",  1'b1, 1'b0, F3_H,  32'h20, 32'hFFFFBEEF, 32'h0, 1'b0);
        op("lw_20b", 1'b0, 1'b1, F3_W,  32'h20, 32'h0, 32'hAA22BEEF, 1'b0);
        op("rdwr_20", 1'b1, 1'b1, F3_W, 32'h20, 32'hDEADBEEF, 32'hAA22BEEF, 1'b0);
        op("lw_20c", 1'b0, 1'b1, F3_W,  32'h20, 32'h0, 32'hDEADBEEF, 1'b0);
        op("rd_off", 1'b0, 1'b0, F3_W,  32'h20, 32'h0, 32'h0, 1'b0);

        op("sw_wrap", 1'b1, 1'b0, F3_W, 32'h100, 32'hCAFEF00D, 32'h0, 1'b0);
        op("lw_wrap", 1'b0, 1'b1, F3_W, 32'h000, 32'h0, 32'hCAFEF00D, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
        op("sw_mis22", 1'b1, 1'b0, F3_W, 32'h22, 32'h55555555, 32'h0, 1'b1);
        op("lw_20d",   1'b0, 1'b1, F3_W, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0);
        op("lh_mis21", 1'b0, 1'b1, F3_H, 32'h21, 32'h0, 32'h0, 1'b1);
        op("lb_21",    1'b0, 1'b1, F3_B, 32'h21, 32'h0, 32'hFFFFFFBE, 1'b0);
`else
        op("lw_al22",  1'b0, 1'b1, F3_W, 32'h22, 32'h0, 32'hDEADBEEF, 1'b0);
        op("sh_al23",  1'b1, 1'b0, F3_H, 32'h23, 32'h00001234, 32'h0, 1'b0);
        op("lw_20d",   1'b0, 1'b1, F3_W, 32'h20, 32'h0, 32'h1234BEEF, 1'b0);
        op("lh_al23",  1'b0, 1'b1, F3_H, 32'h23, 32'h0, 32'h00001234, 1'b0);
`endif

        op("sw_fc", 1'b1, 1'b0, F3_W, 32'hFC, 32'h0F0F0F0F, 32'h0, 1'b0);
        op("lw_fc", 1'b0, 1'b1, F3_W, 32'hFC, 32'h0, 32'h0F0F0F0F, 1'b0);
        idle();
        @(negedge clk);

        reset_and_sweep("rst_abort", 30);
        reset_and_sweep("rst_full", 0);

        op("lw_0_clr",  1'b0, 1'b1, F3_W, 32'h00, 32'h0, 32'h0, 1'b0);
        op("lw_fc_clr", 1'b0, 1'b1, F3_W, 32'hFC, 32'h0, 32'h0, 1'b0);
        op("lw_20_clr", 1'b0, 1'b1, F3_W, 32'h20, 32'h0, 32'h0, 1'b0);
        idle();
        @(negedge clk);
        #5;
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised successor data memory for the single-cycle RISC-V core.
- Byte-addressed, word-organised RAM with RV32I load/store sizing (LB/LH/LW/LBU/LHU, SB/SH/SW) and byte-lane write enables.
- Hardware clear FSM that sweeps the array to zero after reset, with a busy flag to the core.
- Combinational read; synchronous write on clk rising edge.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), word-index width (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- in_address  input  32  byte address; word index = in_address[ADDR_W+1:2]; upper bits ignored, so out-of-range addresses wrap.
- in_write_data  input  32  store data; the low byte/half/word is used according to size.
- in_write_enable  input  1  store request this cycle.
- in_read_enable  input  1  load request this cycle; gates out_data and misalignment checking.
- in_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W.
- out_data  output  32  load result, sign- or zero-extended.
- out_busy  output  1  high while the clear sweep runs.
- out_misaligned  output  1  misaligned-access flag (see Optional Feature).

Behaviour:
- States: CLEAR, READY.
- Any clock edge with reset=0 sets state=CLEAR and clear counter cnt=0; memory contents are not otherwise touched that cycle.
  - Reset values: out_busy=1, out_data=0, out_misaligned=0.
- CLEAR (reset=1): each cycle writes mem[cnt]=0 and increments cnt.
  - When cnt==DEPTH-1 the final word is written and state becomes READY on that edge.
  - The sweep takes exactly DEPTH cycles after reset deasserts.
- Reset reasserted mid-sweep restarts the sweep at cnt=0.
- During CLEAR:
  - Store requests are dropped, not queued.
  - out_data=0 and out_misaligned=0.
  - out_busy=1 combinationally from state.
- READY: out_busy=0.
- Store, READY:
  - Byte lane select = in_address[1:0].
  - SB writes in_write_data[7:0] to the selected lane.
  - SH writes [15:0] to lanes {a1,0},{a1,1}.
  - SW writes all four lanes.
  - Unwritten lanes keep their old value.
  - In-range write completes at the edge and is visible on the same-address read in the next cycle.
- Load, READY, in_read_enable=1, combinational:
  - Extract the lane(s) from mem[index].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- in_read_enable=0: out_data=0.
- Simultaneous load and store to the same word: out_data shows the old contents (pre-edge).
- Misaligned access (H with a[0]=1; W with a[1:0]!=0), macro absent: low offset bits are forced to the natural alignment (H uses a[1]:0, W uses lane 0).
- No X on any output after the first reset edge.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - out_misaligned is high combinationally when READY and (in_write_enable or in_read_enable) and the access is misaligned for its size.
  - A misaligned store is suppressed (no lanes written).
  - A misaligned load returns out_data=0.
- Undefined: out_misaligned tied 0; alignment forcing as in Behaviour.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum dmem_state_t {CLEAR, READY}.
  - Function size_misaligned(funct3, addr[1:0]).
- Sub-module dmem_clear_ctrl: state register, ADDR_W-bit counter, outputs clr_we, clr_idx, busy. The top level holds the array, lane muxing and extension.

Test Plan:
- Hold reset=0 for 2 edges, release; DEPTH=64 -> out_busy=1 for exactly 64 cycles then 0; every LW returns 0x00000000.
- Preload via SW 0x80FF7F01 at 0x10 (after clear); LB 0x10=0x00000001, LB 0x11=0x0000007F, LB 0x12=0xFFFFFFFF, LBU 0x12=0x000000FF, LH 0x12=0xFFFF80FF, LHU 0x12=0x000080FF, LW=0x80FF7F01.
- SW 0x11223344 at 0x20, then SB 0xAA at 0x23 -> LW 0x20=0xAA223344; SH 0xBEEF at 0x20 -> 0xAA22BEEF.
- Reassert reset at sweep cycle 30, release -> busy lasts a full 64 cycles from release; an SW issued during busy is not stored.
- Address wrap: SW 0xCAFEF00D at byte 0x100 with DEPTH=64 -> LW 0x000 returns 0xCAFEF00D.
- With DMEM_MISALIGN_TRAP_EN: SW to 0x22 -> out_misaligned=1, LW 0x20 is unchanged; LH 0x21 -> out_misaligned=1, out_data=0. Without the macro: LW 0x22 returns the word at 0x20, out_misaligned=0.
